serial_operand_transmitter: RTL and testbench
=============================================

Name: serial_operand_transmitter

Overview:
Host-side transmitter for the stochastic add/multiply core's serial operand interface. It holds two 9-bit operands and repeats them back-to-back as 10-bit frames on two serial lanes: 9 data bits LSB-first, then one dummy bit. It sits between a test controller (valid/ready operand load) and the core's ui_in[0]/ui_in[1]. Operand changes are released only after the core has passed an epoch boundary, so each 2^17+1-cycle accumulation window sees one stable operand pair.

Parameters:
DATA_W, 9, operand width in bits.
FRAME_LEN, 10, bits per frame (DATA_W data bits + 1 dummy bit).
CNT_W, 16, width of the frames_sent counter.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; one clock; reset is synchronous and active-high.
op_valid  in  1  operand pair offered.
op_ready  out  1  holding slot empty, so the pair is accepted; combinational: !pend_full && !rst_n.
op_a  in  DATA_W  operand for lane 1.
op_b  in  DATA_W  operand for lane 2.
epoch_start  in  1  one-cycle pulse when the core's clk_counter equals 0.
tx_bit_1  out  1  serial lane 1, drives ui_in[0].
tx_bit_2  out  1  serial lane 2, drives ui_in[1].
frame_start  out  1  high in each cycle where the tx bits carry data bit 0.
busy  out  1  state is RUN.
frames_sent  out  CNT_W  number of completed frames; saturating.

Behaviour:
- Reset values: tx_bit_1/2=0, frame_start=0, busy=0, frames_sent=0, op_ready=0 while rst_n is high. Internal: state=IDLE, bit_idx=0, pend_full=0, epoch_seen=0, active/pending registers=0.
- Accept: a pair is accepted on a clk edge where op_valid && op_ready. op_ready does not depend on op_valid.
- IDLE:
  - Lanes are held at 0.
  - On accept, load active directly (the holding slot stays empty), go to RUN, set bit_idx<=1, drive tx_bit_1<=op_a[0], tx_bit_2<=op_b[0], frame_start<=1.
  - Latency: first bit is visible 1 cycle after the accept edge.
- RUN, each edge, using the current bit_idx:
  - bit_idx 1..8: tx <= active[bit_idx].
  - bit_idx 9: tx <= 0 (dummy bit), frames_sent += 1 (saturates at 2^CNT_W-1).
  - bit_idx 0 (frame boundary): frame_start<=1. If the promotion condition holds, active<=pending, pend_full<=0, epoch_seen<=0, and tx <= new active[0]. Otherwise tx <= active[0].
  - bit_idx then advances, wrapping 9 -> 0.
  - frame_start is 0 on all other edges.
- Promotion condition: pend_full && (epoch_seen || epoch_start). epoch_start arriving on the boundary edge itself counts and is consumed.
- epoch_seen is set by any epoch_start pulse that is not consumed. Multiple pulses before promotion are equivalent to one.
- Holding slot (RUN only):
  - On accept, pending<=pair and pend_full<=1.
  - A slot freed by promotion shows op_ready=1 from the next cycle. There is no same-cycle pass-through.
- The active frame repeats indefinitely. There is no return to IDLE except by reset.
- Reset mid-frame: synchronous. All state returns to reset values on that edge, the pending pair is discarded, and the lanes are 0 from the next cycle.
- Both lanes always share bit_idx and frame alignment.

Decomposition:
- Shared package stochastic_pkg holds:
  - DATA_W=9, FRAME_LEN=10, EPOCH_LEN=131073;
  - the state encoding (IDLE, RUN);
  - a DUMMY_BIT=1'b0 constant.
- One sub-module, frame_lane_mux, instantiated twice:
  - inputs: active and pending words, bit_idx, promote;
  - output: next tx bit (combinational).
- The top level owns bit_idx, the FSM, the holding slot, epoch_seen and frames_sent.

Test Plan:
1. Reset, then op_a=9'h1A5, op_b=9'h05A with op_valid for 1 cycle in IDLE -> op_ready stays 1 after the accept edge. Each frame:
   - tx_bit_1 = 1,0,1,0,0,1,0,1,1,0;
   - tx_bit_2 = 0,1,0,1,1,0,1,0,0,0.
   frame_start pulses every 10 cycles starting 1 cycle after accept, busy=1, and frames_sent=3 after 30 cycles.
2. While running 9'h1A5/9'h05A, offer 9'h0FF/9'h100 with no epoch_start -> accepted, op_ready=0, lanes unchanged for 50 frames. Pulse epoch_start at bit_idx 4 -> lane 1 = 1,1,1,1,1,1,1,1,0,0 from the next frame_start, and op_ready=1 the cycle after.
3. epoch_start on the same edge as a frame boundary with pend_full=1 -> switch occurs in that frame, and epoch_seen=0 afterwards (a further pair then waits for a new pulse).
4. op_valid held high with op_ready=0 across 3 frames -> no accept; pending keeps its first value; second operand values never appear.
5. Assert rst_n while bit_idx=4 with pend_full=1 -> next cycle tx_bit_1/2=0, busy=0, frames_sent=0. After release, op_ready=1 and a new accept restarts at bit 0 with no stale pending pair emitted.
6. Run 65540 frames -> frames_sent saturates at 16'hFFFF. Loopback into the core's serial input receiver then yields 9'h1A5/9'h05A after one epoch.

Source files
------------

// File: rtl/stochastic_pkg.sv
// Shared constants and types for the stochastic core's serial operand path.
//   DATA_W    : operand width in bits
//   FRAME_LEN : bits per serial frame (data bits plus one trailing dummy bit)
//   EPOCH_LEN : core accumulation window length in clock cycles
//   IDX_W     : width of a bit index within a frame
//   DUMMY_BIT : value driven in the last slot of every frame
//   state_e   : transmitter FSM encoding
package stochastic_pkg;

  localparam int unsigned DATA_W    = 9;
  localparam int unsigned FRAME_LEN = DATA_W + 1;
  localparam int unsigned EPOCH_LEN = 131073;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  localparam logic DUMMY_BIT = 1'b0;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/serial_operand_transmitter_if.sv
// Operand load handshake between the test controller and the transmitter.
//   op_valid : controller offers an operand pair
//   op_ready : transmitter can accept the pair this cycle
//   op_a     : operand for serial lane 1
//   op_b     : operand for serial lane 2
// Modports: master = test controller, slave = transmitter.
interface serial_operand_transmitter_if;
  import stochastic_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  modport master (
    output op_valid,
    output op_a,
    output op_b,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_a,
    input  op_b,
    output op_ready
  );

endinterface

// File: rtl/frame_lane_mux.sv
// Selects the next serial bit for one lane.
//   active  : operand currently being framed
//   pending : operand waiting in the holding slot
//   bit_idx : frame position whose bit is to be driven next
//   promote : pending replaces active on this frame boundary
//   tx_next : bit to register onto the lane (combinational)
module frame_lane_mux
  import stochastic_pkg::*;
(
  input  logic [DATA_W-1:0] active,
  input  logic [DATA_W-1:0] pending,
  input  logic [IDX_W-1:0]  bit_idx,
  input  logic              promote,
  output logic              tx_next
);

  logic [DATA_W-1:0] word;

  // promote is only ever raised at bit_idx 0, so selecting the whole word here
  // is equivalent to substituting pending[0] on the boundary.
  assign word = promote ? pending : active;

  always_comb begin
    tx_next = DUMMY_BIT;
    if (bit_idx < IDX_W'(DATA_W)) begin
      tx_next = word[bit_idx];
    end
  end

endmodule

// File: rtl/serial_operand_transmitter.sv
// Host-side transmitter for the stochastic core's serial operand inputs.
// Repeats the active operand pair as LSB-first 10-bit frames (9 data bits and a
// dummy bit) on two lanes; a newly loaded pair is only swapped in on a frame
// boundary after the core has started a new epoch.
//   clk         : system clock
//   rst_n       : synchronous reset, active high despite its name
//   op_if       : operand load handshake (slave side)
//   epoch_start : one-cycle pulse at the core's epoch boundary
//   tx_bit_1/2  : serial lanes to the core's ui_in[0]/ui_in[1]
//   frame_start : lanes carry data bit 0 this cycle
//   busy        : transmitter is framing an operand pair
//   frames_sent : completed frames, saturating
module serial_operand_transmitter
  import stochastic_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serial_operand_transmitter_if.slave op_if,
  input  logic                        epoch_start,
  output logic                        tx_bit_1,
  output logic                        tx_bit_2,
  output logic                        frame_start,
  output logic                        busy,
  output logic [CNT_W-1:0]            frames_sent
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  state_e            state_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              pend_full_q;
  logic              epoch_seen_q;
  logic [DATA_W-1:0] active_a_q;
  logic [DATA_W-1:0] active_b_q;
  logic [DATA_W-1:0] pend_a_q;
  logic [DATA_W-1:0] pend_b_q;
  logic              tx_bit_1_q;
  logic              tx_bit_2_q;
  logic              frame_start_q;
  logic [CNT_W-1:0]  frames_sent_q;

  logic accept;
  logic promote;
  logic lane_1_next;
  logic lane_2_next;

  assign op_if.op_ready = !pend_full_q && !rst_n;
  assign accept         = op_if.op_valid && op_if.op_ready;

  // An epoch pulse landing on the boundary edge itself is enough to promote.
  assign promote = (state_q == StRun) && (bit_idx_q == '0) && pend_full_q &&
                   (epoch_seen_q || epoch_start);

  frame_lane_mux u_lane_1 (
    .active  (active_a_q),
    .pending (pend_a_q),
    .bit_idx (bit_idx_q),
    .promote (promote),
    .tx_next (lane_1_next)
  );

  frame_lane_mux u_lane_2 (
    .active  (active_b_q),
    .pending (pend_b_q),
    .bit_idx (bit_idx_q),
    .promote (promote),
    .tx_next (lane_2_next)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q       <= StIdle;
      bit_idx_q     <= '0;
      pend_full_q   <= 1'b0;
      epoch_seen_q  <= 1'b0;
      active_a_q    <= '0;
      active_b_q    <= '0;
      pend_a_q      <= '0;
      pend_b_q      <= '0;
      tx_bit_1_q    <= 1'b0;
      tx_bit_2_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      frame_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_bit_1_q <= 1'b0;
          tx_bit_2_q <= 1'b0;
          if (epoch_start) begin
            epoch_seen_q <= 1'b1;
          end
          // First pair skips the holding slot and goes straight on air.
          if (accept) begin
            active_a_q    <= op_if.op_a;
            active_b_q    <= op_if.op_b;
            state_q       <= StRun;
            bit_idx_q     <= IDX_W'(1);
            tx_bit_1_q    <= op_if.op_a[0];
            tx_bit_2_q    <= op_if.op_b[0];
            frame_start_q <= 1'b1;
          end
        end
        StRun: begin
          tx_bit_1_q <= lane_1_next;
          tx_bit_2_q <= lane_2_next;
          if (bit_idx_q == '0) begin
            frame_start_q <= 1'b1;
          end
          if (bit_idx_q == LastIdx) begin
            bit_idx_q <= '0;
            if (frames_sent_q != CntMax) begin
              frames_sent_q <= frames_sent_q + CNT_W'(1);
            end
          end else begin
            bit_idx_q <= bit_idx_q + IDX_W'(1);
          end
          if (promote) begin
            active_a_q   <= pend_a_q;
            active_b_q   <= pend_b_q;
            pend_full_q  <= 1'b0;
            epoch_seen_q <= 1'b0;
          end else if (epoch_start) begin
            epoch_seen_q <= 1'b1;
          end
          // accept needs an empty slot and promote needs a full one, so the
          // two never coincide.
          if (accept) begin
            pend_a_q    <= op_if.op_a;
            pend_b_q    <= op_if.op_b;
            pend_full_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign tx_bit_1    = tx_bit_1_q;
  assign tx_bit_2    = tx_bit_2_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == StRun);
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_serial_operand_transmitter.sv
// Bench for serial_operand_transmitter: directed operand pairs, expected frames
// queued by the stimulus thread and checked by an independent frame monitor.
module tb_serial_operand_transmitter;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             epoch_start;
  logic             tx_bit_1;
  logic             tx_bit_2;
  logic             frame_start;
  logic             busy;
  logic [CNT_W-1:0] frames_sent;

  serial_operand_transmitter_if op_if ();

  serial_operand_transmitter #(
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_if       (op_if),
    .epoch_start (epoch_start),
    .tx_bit_1    (tx_bit_1),
    .tx_bit_2    (tx_bit_2),
    .frame_start (frame_start),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // l1/l2 bit i is the lane value in frame slot i; slot 9 is the dummy bit.
  typedef struct packed {
    logic [9:0] l1;
    logic [9:0] l2;
  } frame_t;

  frame_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [8:0] a, input logic [8:0] b);
    exp_q.push_back({1'b0, a, 1'b0, b});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = (frame_start === 1'b1);
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL frame_start_timeout: got none within 40 cycles, required one");
    end
  endtask

  task automatic run_frames(input int n, input logic [8:0] a, input logic [8:0] b);
    repeat (n) begin
      wait_fs();
      push_frame(a, b);
    end
  endtask

  // Monitor: captures each 10-cycle frame beginning at frame_start and
  // compares it against the oldest queued expectation.
  initial begin
    logic [9:0] c1;
    logic [9:0] c2;
    logic [9:0] cfs;
    int         pos;
    bit         cap;
    frame_t     e;
    cap = 1'b0;
    pos = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b0 || busy !== 1'b1) begin
        cap = 1'b0;
        pos = 0;
      end else begin
        if (!cap && frame_start === 1'b1) begin
          cap = 1'b1;
          pos = 0;
        end
        if (cap) begin
          c1[pos[3:0]]  = tx_bit_1;
          c2[pos[3:0]]  = tx_bit_2;
          cfs[pos[3:0]] = frame_start;
          pos++;
          if (pos == 10) begin
            cap = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL frame_underflow: got l1=%b l2=%b, required no frame", c1, c2);
            end else begin
              e = exp_q.pop_front();
              if (c1 !== e.l1 || c2 !== e.l2 || cfs !== 10'b00_0000_0001) begin
                errors++;
                $display("FAIL frame: got l1=%b l2=%b fs=%b, required l1=%b l2=%b fs=%b",
                         c1, c2, cfs, e.l1, e.l2, 10'b00_0000_0001);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b1;
    epoch_start    = 1'b0;
    op_if.op_valid = 1'b0;
    op_if.op_a     = '0;
    op_if.op_b     = '0;
    step(2);

    // Reset state
    chk("rst_op_ready", 32'(op_if.op_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx1", 32'(tx_bit_1), 0);
    chk("rst_tx2", 32'(tx_bit_2), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_frames_sent", 32'(frames_sent), 0);
    rst_n = 1'b0;
    step(1);
    chk("idle_op_ready", 32'(op_if.op_ready), 1);
    chk("idle_tx1", 32'(tx_bit_1), 0);

    // 1: first pair from IDLE, bit 0 one cycle after accept
    op_if.op_valid = 1'b1;
    op_if.op_a     = 9'h1A5;
    op_if.op_b     = 9'h05A;
    step(1);
    op_if.op_valid = 1'b0;
    chk("t1_op_ready_after_accept", 32'(op_if.op_ready), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_first_frame_start", 32'(frame_start), 1);
    push_frame(9'h1A5, 9'h05A);
    run_frames(2, 9'h1A5, 9'h05A);
    step(9);
    chk("t1_frames_sent_3", 32'(frames_sent), 3);

    // 2: pair held without epoch for 50 frames, promoted after mid-frame pulse
    wait_fs();
    push_frame(9'h1A5, 9'h05A);
    op_if.op_valid = 1'b1;
    op_if.op_a     = 9'h0FF;
    op_if.op_b     = 9'h100;
    step(1);
    op_if.op_valid = 1'b0;
    chk("t2_op_ready_full", 32'(op_if.op_ready), 0);
    run_frames(50, 9'h1A5, 9'h05A);
    step(3);
    epoch_start = 1'b1;
    step(1);
    epoch_start = 1'b0;
    wait_fs();
    push_frame(9'h0FF, 9'h100);
    chk("t2_op_ready_freed", 32'(op_if.op_ready), 1);

    // 3: epoch pulse on the boundary edge itself
    op_if.op_valid = 1'b1;
    op_if.op_a     = 9'h0C3;
    op_if.op_b     = 9'h13C;
    step(1);
    op_if.op_valid = 1'b0;
    step(8);
    epoch_start = 1'b1;
    wait_fs();
    epoch_start = 1'b0;
    push_frame(9'h0C3, 9'h13C);
    chk("t3_op_ready_freed", 32'(op_if.op_ready), 1);

    // 4: epoch_seen was consumed; a new pair waits, later offers are refused
    op_if.op_valid = 1'b1;
    op_if.op_a     = 9'h1F0;
    op_if.op_b     = 9'h00F;
    step(1);
    op_if.op_a = 9'h0AA;
    op_if.op_b = 9'h155;
    chk("t4_op_ready_full", 32'(op_if.op_ready), 0);
    run_frames(3, 9'h0C3, 9'h13C);
    op_if.op_valid = 1'b0;
    chk("t4_op_ready_still_full", 32'(op_if.op_ready), 0);
    epoch_start = 1'b1;
    step(1);
    epoch_start = 1'b0;
    wait_fs();
    push_frame(9'h1F0, 9'h00F);

    // 5: reset mid-frame with a pair pending
    op_if.op_valid = 1'b1;
    op_if.op_a     = 9'h111;
    op_if.op_b     = 9'h0EE;
    step(1);
    op_if.op_valid = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("t5_rst_tx1", 32'(tx_bit_1), 0);
    chk("t5_rst_tx2", 32'(tx_bit_2), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_frames_sent", 32'(frames_sent), 0);
    chk("t5_rst_op_ready", 32'(op_if.op_ready), 0);
    exp_q.delete();
    rst_n = 1'b0;
    step(1);
    chk("t5_op_ready_released", 32'(op_if.op_ready), 1);
    chk("t5_idle_busy", 32'(busy), 0);
    op_if.op_valid = 1'b1;
    op_if.op_a     = 9'h0E7;
    op_if.op_b     = 9'h118;
    step(1);
    op_if.op_valid = 1'b0;
    chk("t5_restart_frame_start", 32'(frame_start), 1);
    chk("t5_restart_tx1", 32'(tx_bit_1), 1);
    chk("t5_restart_tx2", 32'(tx_bit_2), 0);
    push_frame(9'h0E7, 9'h118);
    // A stale pending pair would be promoted by this pulse.
    epoch_start = 1'b1;
    step(1);
    epoch_start = 1'b0;

    // 6: frames_sent counts then saturates at all-ones
    run_frames(9, 9'h0E7, 9'h118);
    chk("t6_frames_sent_9", 32'(frames_sent), 9);
    run_frames(8, 9'h0E7, 9'h118);
    chk("t6_frames_sent_sat", 32'(frames_sent), 32'hF);
    step(10);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    rst_n = 1'b1;
    step(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
